// File: rtl/disparity_frame_writer.sv
// Packs 16-bit disparity pixels two per word and writes them as fixed-length
// Avalon-MM bursts into a double-buffered frame store.
module disparity_frame_writer #(
  parameter int unsigned       frame_w      = 120,
  parameter int unsigned       frame_h      = 240,
  parameter int unsigned       burst_len    = 8,
  parameter int unsigned       addr_w       = 32,
  parameter logic [addr_w-1:0] base_addr    = '0,
  parameter logic [addr_w-1:0] frame_stride = addr_w'(32'h0002_0000)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                disparity,
  input  logic                       disparity_valid,
  output logic                       disparity_ready,
  output logic [addr_w-1:0]          avm_address,
  output logic                       avm_write,
  output logic [31:0]                avm_writedata,
  output logic [$clog2(burst_len):0] avm_burstcount,
  input  logic                       avm_waitrequest,
  output logic                       frame_done,
  output logic                       done_buffer,
  output logic [15:0]                frame_count
);

  localparam int unsigned WPF   = (frame_w * frame_h) / 2;
  localparam int unsigned WLW   = $clog2(WPF + 1);
  localparam int unsigned DEPTH = 2 * burst_len;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned BCW   = $clog2(burst_len) + 1;

  typedef enum logic [1:0] {IDLE, BURST, FRAME_END} state_t;

  state_t             state_q;
  logic               half_q;
  logic [15:0]        low_q;
  logic [31:0]        mem_q [DEPTH];
  logic [PW-1:0]      wr_idx_q;
  logic [PW-1:0]      rd_idx_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               fifo_full;
  logic               hs;
  logic               push;
  logic               pop;
  logic [31:0]        need;

  logic               avm_write_q;
  logic [addr_w-1:0]  avm_address_q;
  logic [BCW-1:0]     avm_burstcount_q;
  logic [BCW-1:0]     beats_left_q;
  logic [WLW-1:0]     words_left_q;
  logic [addr_w-1:0]  wr_ptr_q;
  logic               wr_buf_q;
  logic               frame_done_q;
  logic               done_buffer_q;
  logic [15:0]        frame_count_q;

  assign fifo_full       = (count_q == CW'(DEPTH));
  assign disparity_ready = !reset && (!half_q || !fifo_full);
  assign hs              = disparity_valid && disparity_ready;
  assign push            = hs && half_q;
  assign pop             = avm_write_q && !avm_waitrequest;

  // Next FIFO occupancy; IDLE uses it so a burst can start the cycle after its last push.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  assign need = (32'(words_left_q) < burst_len) ? 32'(words_left_q) : burst_len;

  // Pixel pairing and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q   <= 1'b0;
      low_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (hs) begin
        half_q <= ~half_q;
        if (!half_q) begin
          low_q <= disparity;
        end
      end
      if (push) begin
        wr_idx_q <= wr_idx_q + PW'(1);
      end
      if (pop) begin
        rd_idx_q <= rd_idx_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx_q] <= {disparity, low_q};
    end
  end

  // Burst sequencing and frame bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      avm_write_q      <= 1'b0;
      avm_address_q    <= base_addr;
      avm_burstcount_q <= '0;
      beats_left_q     <= '0;
      words_left_q     <= WLW'(WPF);
      wr_ptr_q         <= base_addr;
      wr_buf_q         <= 1'b0;
      frame_done_q     <= 1'b0;
      done_buffer_q    <= 1'b1;
      frame_count_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (32'(count_d) >= need) begin
            state_q          <= BURST;
            avm_write_q      <= 1'b1;
            avm_address_q    <= wr_ptr_q;
            avm_burstcount_q <= BCW'(need);
            beats_left_q     <= BCW'(need);
          end
        end
        BURST: begin
          if (pop) begin
            words_left_q <= words_left_q - WLW'(1);
            beats_left_q <= beats_left_q - BCW'(1);
            if (beats_left_q == BCW'(1)) begin
              avm_write_q <= 1'b0;
              wr_ptr_q    <= wr_ptr_q + (addr_w'(avm_burstcount_q) << 2);
              if (words_left_q == WLW'(1)) begin
                state_q       <= FRAME_END;
                frame_done_q  <= 1'b1;
                done_buffer_q <= wr_buf_q;
                frame_count_q <= frame_count_q + 16'd1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        FRAME_END: begin
          wr_buf_q     <= ~wr_buf_q;
          wr_ptr_q     <= wr_buf_q ? base_addr : base_addr + frame_stride;
          words_left_q <= WLW'(WPF);
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;
  assign avm_writedata  = mem_q[rd_idx_q];
  assign frame_done     = frame_done_q;
  assign done_buffer    = done_buffer_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_disparity_frame_writer.sv
// Directed bench: a 4x4/burst-4 writer (A) and a 6x2/burst-4 writer (B) checked
// beat by beat against a small address/data model.
module tb_disparity_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  int          n_total = 0;
  int          n_bad   = 0;

  logic [15:0] a_disp, b_disp;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_addr, b_addr, a_data, b_data;
  logic        a_write, b_write, a_wait, b_wait;
  logic [2:0]  a_bc, b_bc;
  logic        a_fd, b_fd, a_db, b_db;
  logic [15:0] a_fc, b_fc;

  int pix_a, sent_a, beat_a, frame_a, beats_tot_a, fd_cnt_a, stall_seen_a;
  int pix_b, sent_b, beat_b, frame_b, beats_tot_b, fd_cnt_b;
  bit hs_a, hs_b;

  always #5 clk = ~clk;

  disparity_frame_writer #(.frame_w(4), .frame_h(4), .burst_len(4)) u_a (
    .clk(clk), .reset(reset), .disparity(a_disp), .disparity_valid(a_valid),
    .disparity_ready(a_ready), .avm_address(a_addr), .avm_write(a_write),
    .avm_writedata(a_data), .avm_burstcount(a_bc), .avm_waitrequest(a_wait),
    .frame_done(a_fd), .done_buffer(a_db), .frame_count(a_fc)
  );

  disparity_frame_writer #(.frame_w(6), .frame_h(2), .burst_len(4)) u_b (
    .clk(clk), .reset(reset), .disparity(b_disp), .disparity_valid(b_valid),
    .disparity_ready(b_ready), .avm_address(b_addr), .avm_write(b_write),
    .avm_writedata(b_data), .avm_burstcount(b_bc), .avm_waitrequest(b_wait),
    .frame_done(b_fd), .done_buffer(b_db), .frame_count(b_fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat model: 16 pixels per frame, buffer alternates per frame, bursts of 4 words.
  task automatic mon_a();
    int p;
    if (a_write) begin
      p = frame_a * 16 + 2 * beat_a;
      check("a_addr", a_addr, 32'((frame_a % 2) * 32'h20000 + (beat_a / 4) * 16));
      check("a_bc", 32'(a_bc), 32'd4);
      check("a_data", a_data, {16'(p + 1), 16'(p)});
      if (!a_wait) begin
        beat_a++;
        beats_tot_a++;
        if (beat_a == 8) begin
          beat_a = 0;
          frame_a++;
        end
      end else begin
        stall_seen_a++;
      end
    end
    if (a_fd) fd_cnt_a++;
  endtask

  // Six words per frame: a burst of 4 then a tail burst of 2.
  task automatic mon_b();
    int p;
    if (b_write) begin
      p = frame_b * 12 + 2 * beat_b;
      check("b_addr", b_addr, 32'((frame_b % 2) * 32'h20000 + (beat_b / 4) * 16));
      check("b_bc", 32'(b_bc), (beat_b < 4) ? 32'd4 : 32'd2);
      check("b_data", b_data, {16'(p + 1), 16'(p)});
      if (!b_wait) begin
        beat_b++;
        beats_tot_b++;
        if (beat_b == 6) begin
          beat_b = 0;
          frame_b++;
        end
      end
    end
    if (b_fd) fd_cnt_b++;
  endtask

  task automatic tick();
    @(negedge clk);
    mon_a();
    mon_b();
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (hs_a) begin pix_a++; sent_a++; end
    if (hs_b) begin pix_b++; sent_b++; end
  endtask

  task automatic run_a(input int npix, input int stall_beat, input int stall_len,
                       input int max_cyc, input int fd_target);
    int  stalled;
    bit  done;
    stalled      = 0;
    done         = 1'b0;
    sent_a       = 0;
    fd_cnt_a     = 0;
    beats_tot_a  = 0;
    stall_seen_a = 0;
    a_valid      = (npix > 0);
    a_disp       = 16'(pix_a);
    a_wait       = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      a_valid = (sent_a < npix);
      a_disp  = 16'(pix_a);
      a_wait  = 1'b0;
      if (a_write && beat_a == stall_beat && stalled < stall_len) begin
        a_wait = 1'b1;
        stalled++;
      end
      done = (fd_target > 0) && (fd_cnt_a >= fd_target) && (sent_a == npix);
    end
    a_valid = 1'b0;
    a_wait  = 1'b0;
    if (fd_target > 0) check("a_frame_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_b(input int npix, input int max_cyc, input int fd_target);
    bit done;
    done        = 1'b0;
    sent_b      = 0;
    fd_cnt_b    = 0;
    beats_tot_b = 0;
    b_valid     = (npix > 0);
    b_disp      = 16'(pix_b);
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      b_valid = (sent_b < npix);
      b_disp  = 16'(pix_b);
      done    = (fd_cnt_b >= fd_target) && (sent_b == npix);
    end
    b_valid = 1'b0;
    check("b_frame_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_disp = '0; a_wait = 1'b0;
    b_valid = 1'b0; b_disp = '0; b_wait = 1'b0;
    pix_a = 0; sent_a = 0; beat_a = 0; frame_a = 0; beats_tot_a = 0; fd_cnt_a = 0;
    stall_seen_a = 0;
    pix_b = 0; sent_b = 0; beat_b = 0; frame_b = 0; beats_tot_b = 0; fd_cnt_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_write", 32'(a_write), 32'd0);
    check("rst_addr", a_addr, 32'h0);
    check("rst_bc", 32'(a_bc), 32'd0);
    check("rst_fd", 32'(a_fd), 32'd0);
    check("rst_db", 32'(a_db), 32'd1);
    check("rst_fc", 32'(a_fc), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Frame 0, no stalls: bursts at 0x0 and 0x10.
    run_a(16, -1, 0, 200, 1);
    repeat (3) tick();
    check("f0_fd_pulses", 32'(fd_cnt_a), 32'd1);
    check("f0_db", 32'(a_db), 32'd0);
    check("f0_fc", 32'(a_fc), 32'd1);
    check("f0_beats", 32'(beats_tot_a), 32'd8);

    // Frame 1 into buffer 1 with a 3-cycle stall on beat 2.
    run_a(16, 1, 3, 200, 1);
    repeat (3) tick();
    check("f1_fd_pulses", 32'(fd_cnt_a), 32'd1);
    check("f1_db", 32'(a_db), 32'd1);
    check("f1_fc", 32'(a_fc), 32'd2);
    check("f1_beats", 32'(beats_tot_a), 32'd8);
    check("f1_stalls", 32'(stall_seen_a), 32'd3);

    // Frame 2 returns to buffer 0.
    run_a(16, -1, 0, 200, 1);
    repeat (3) tick();
    check("f2_db", 32'(a_db), 32'd0);
    check("f2_fc", 32'(a_fc), 32'd3);
    check("f2_beats", 32'(beats_tot_a), 32'd8);

    // Six-word frame: tail burst of 2 at 0x10.
    run_b(12, 200, 1);
    repeat (3) tick();
    check("b_fd_pulses", 32'(fd_cnt_b), 32'd1);
    check("b_db", 32'(b_db), 32'd0);
    check("b_fc", 32'(b_fc), 32'd1);
    check("b_beats", 32'(beats_tot_b), 32'd6);

    // Permanent stall: 8 words buffered plus one latched low half.
    run_a(40, 0, 1000, 60, 0);
    check("full_accepted", 32'(sent_a), 32'd17);
    check("full_ready", 32'(a_ready), 32'd0);
    check("full_write", 32'(a_write), 32'd1);
    check("full_beats", 32'(beats_tot_a), 32'd0);

    // Release two beats, then reset mid-burst.
    tick();
    tick();
    check("mid_beats", 32'(beat_a), 32'd2);
    reset = 1'b1;
    #1;
    check("midrst_write", 32'(a_write), 32'd0);
    check("midrst_fc", 32'(a_fc), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd0);
    pix_a = 0; beat_a = 0; frame_a = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_a(16, -1, 0, 200, 1);
    repeat (3) tick();
    check("post_fd_pulses", 32'(fd_cnt_a), 32'd1);
    check("post_db", 32'(a_db), 32'd0);
    check("post_fc", 32'(a_fc), 32'd1);
    check("post_beats", 32'(beats_tot_a), 32'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/disparity_frame_writer.md
Name: disparity_frame_writer

Overview:
- Sink end of the filtered disparity stream: accepts 16-bit disparity pixels over valid/ready and packs them two per 32-bit word.
- Buffers the packed words and writes them as fixed-length Avalon-MM bursts into a double-buffered frame store in external memory.
- Sits downstream of the disparity filtering system and upstream of the display/readback path.
- Reports which buffer holds the last complete frame.

Parameters:
- frame_w, 120, decimated frame width in pixels; must be even.
- frame_h, 240, decimated frame height in rows.
- burst_len, 8, words per Avalon burst; power of 2, 2..64.
- addr_w, 32, Avalon byte-address width.
- base_addr, 32'h0000_0000, byte address of buffer 0.
- frame_stride, 32'h0002_0000, byte offset between buffer 0 and buffer 1; must be >= frame_w*frame_h*2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- disparity  in  16  disparity pixel, raster order.
- disparity_valid  in  1  pixel valid.
- disparity_ready  out  1  pixel accepted when valid&&ready.
- avm_address  out  addr_w  burst start byte address.
- avm_write  out  1  write request.
- avm_writedata  out  32  packed word; pixel n in [15:0], pixel n+1 in [31:16].
- avm_burstcount  out  $clog2(burst_len)+1  beats in the current burst.
- avm_waitrequest  in  1  slave stall.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- done_buffer  out  1  buffer index of the most recently completed frame.
- frame_count  out  16  completed frames, wraps at 16'hFFFF->0.

Behaviour:
- Reset values: disparity_ready=0 while reset is asserted; avm_write=0; avm_address=base_addr; avm_burstcount=0; frame_done=0; done_buffer=1; frame_count=0; write buffer=0; FIFO empty; pack half=0.
- Packing: a handshake with half=0 latches the pixel into the low register and sets half=1.
  - A handshake with half=1 pushes {pixel, low} into the word FIFO and sets half=0.
- disparity_ready = (half==0) || !fifo_full.
  - The low-half register never blocks.
  - Registered FIFO, depth 2*burst_len words; simultaneous push and pop in one cycle is allowed.
- Word accounting: words_per_frame = frame_w*frame_h/2.
  - words_left counts down per beat accepted and reloads on frame end.
- FSM states: IDLE, BURST, FRAME_END.
- IDLE -> BURST when fifo_count >= min(burst_len, words_left).
  - On entry: latch avm_burstcount = min(burst_len, words_left); avm_address = current write pointer.
- BURST:
  - avm_write=1; avm_writedata = FIFO head.
  - A beat is accepted when avm_write && !avm_waitrequest; this pops the FIFO and decrements the beat counter.
  - avm_address and avm_burstcount are held constant for the whole burst.
  - Data, address and burstcount are held stable while waitrequest is asserted.
  - avm_write never deasserts mid-burst; entry guarantees the data is already buffered.
  - On the last beat accepted: write pointer += burstcount*4.
  - Next state is FRAME_END if words_left reaches 0, else IDLE.
- FRAME_END (1 cycle):
  - frame_done=1; done_buffer = write buffer; frame_count++.
  - Toggle write buffer; write pointer = base_addr + new_buffer*frame_stride; words_left reloads.
  - Next state IDLE.
  - Pixel acceptance continues during FRAME_END; the FIFO keeps filling.
- Tail burst: if words_per_frame is not a multiple of burst_len, the final burst of the frame is shorter (burstcount = words_left).
- Bursts never straddle frames.
- Minimum latency: the last word of a burst is pushed in cycle N, avm_write rises in cycle N+1.
- Mid-operation reset: all state clears immediately, including an in-flight burst. The system must only reset between frames or with the memory port quiesced.

Test Plan:
- frame_w=4, frame_h=4, burst_len=4, no stalls; send pixels 0..15 -> two bursts of 4 at addresses 0x0 and 0x10.
  - First word 32'h0001_0000, last word 32'h000F_000E.
  - frame_done pulses once; done_buffer=0; frame_count=1.
- Same config, waitrequest high for 3 cycles on beat 2 -> address, burstcount=4 and data held stable while stalled; beat count still 8; no data lost.
- Two consecutive frames -> second frame starts at 0x20000; done_buffer toggles 0 then 1; frame_count=2.
  - Third frame returns to address 0x0.
- frame_w=6, frame_h=2, burst_len=4 (6 words) -> bursts of 4 then 2 beats.
  - Second burst address 0x10, avm_burstcount=2.
- Hold waitrequest high indefinitely with 40 pixels offered -> disparity_ready drops once the FIFO is full with 8 words and the low half is latched (17 pixels accepted); no overflow.
- Assert reset mid-burst -> avm_write=0 and frame_count=0 in the same cycle.
  - After release, the next frame writes from base_addr cleanly.
